// File: rtl/hline_axi_arb.sv
// Two-requester round-robin arbiter in front of a single AXI-style master.
// Lock lets one requester keep the master across back-to-back transactions.
module hline_axi_arb #(
    parameter int ADDR_W = 32,
    parameter int BL_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req_0,
    input  logic              wr_req_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [BL_W-1:0]   burst_length_0,
    input  logic              lock_0,
    output logic              grant_0,
    output logic              done_0,
    input  logic              rd_req_1,
    input  logic              wr_req_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [BL_W-1:0]   burst_length_1,
    input  logic              lock_1,
    output logic              grant_1,
    output logic              done_1,
    output logic              m_rd_req,
    output logic              m_wr_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [BL_W-1:0]   m_burst_length,
    input  logic              m_axi_done,
    output logic [1:0]        curr_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              own_q, own_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        done_q, done_d;
    logic              m_rd_q, m_rd_d;
    logic              m_wr_q, m_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BL_W-1:0]   bl_q, bl_d;

    logic              elig0, elig1, win, src;
    logic              src_rd, src_wr, src_lock, src_go;
    logic [ADDR_W-1:0] src_addr;
    logic [BL_W-1:0]   src_bl;

    // In IDLE the round-robin winner is the source; otherwise the owner.
    always_comb begin
        elig0 = rd_req_0 | wr_req_0;
        elig1 = rd_req_1 | wr_req_1;
        win   = (elig0 & elig1) ? rr_q : elig1;
        src   = (state_q == IDLE) ? win : own_q;
        src_rd   = src ? rd_req_1 : rd_req_0;
        src_wr   = src ? wr_req_1 : wr_req_0;
        src_lock = src ? lock_1 : lock_0;
        src_addr = src ? addr_1 : addr_0;
        src_bl   = src ? burst_length_1 : burst_length_0;
        src_go   = 1'b0;
        if (state_q == IDLE) src_go = elig0 | elig1;
        if (state_q == HOLD) src_go = src_rd | src_wr;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        own_d   = own_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        m_rd_d  = m_rd_q;
        m_wr_d  = m_wr_q;
        addr_d  = addr_q;
        bl_d    = bl_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (src_go) begin
                    own_d   = src;
                    grant_d = src ? 2'b10 : 2'b01;
                    addr_d  = src_addr;
                    bl_d    = src_bl;
                    // Zero-length bursts finish without touching the master.
                    if (src_bl == '0) begin
                        done_d  = src ? 2'b10 : 2'b01;
                        state_d = RELEASE;
                    end else begin
                        m_rd_d  = src_rd;
                        m_wr_d  = src_wr & ~src_rd;
                        state_d = BUSY;
                    end
                end else if (state_q == HOLD && !src_lock) begin
                    grant_d = 2'b00;
                    rr_d    = ~own_q;
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (m_axi_done) begin
                    m_rd_d  = 1'b0;
                    m_wr_d  = 1'b0;
                    done_d  = grant_q;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (src_lock) begin
                    state_d = HOLD;
                end else begin
                    grant_d = 2'b00;
                    rr_d    = ~own_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            own_q   <= 1'b0;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            m_rd_q  <= 1'b0;
            m_wr_q  <= 1'b0;
            addr_q  <= '0;
            bl_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            m_rd_q  <= m_rd_d;
            m_wr_q  <= m_wr_d;
            addr_q  <= addr_d;
            bl_q    <= bl_d;
        end
    end

    assign grant_0        = grant_q[0];
    assign grant_1        = grant_q[1];
    assign done_0         = done_q[0];
    assign done_1         = done_q[1];
    assign m_rd_req       = m_rd_q;
    assign m_wr_req       = m_wr_q;
    assign m_addr         = addr_q;
    assign m_burst_length = bl_q;
    assign curr_state     = state_q;

endmodule

// File: tb/tb_hline_axi_arb.sv
// Scoreboard bench for hline_axi_arb: transaction-level arbitration model,
// randomized requesters and master, monitor comparing each done pulse.
module tb_hline_axi_arb;

    logic        clk;
    logic        reset;
    logic        rd_req [2];
    logic        wr_req [2];
    logic [31:0] addr [2];
    logic [11:0] bl [2];
    logic        lock [2];
    logic        grant_0, grant_1, done_0, done_1;
    logic        m_rd_req, m_wr_req;
    logic [31:0] m_addr;
    logic [11:0] m_burst_length;
    logic        m_axi_done;
    logic [1:0]  curr_state;

    hline_axi_arb dut (
        .clk(clk), .reset(reset),
        .rd_req_0(rd_req[0]), .wr_req_0(wr_req[0]),
        .addr_0(addr[0]), .burst_length_0(bl[0]), .lock_0(lock[0]),
        .grant_0(grant_0), .done_0(done_0),
        .rd_req_1(rd_req[1]), .wr_req_1(wr_req[1]),
        .addr_1(addr[1]), .burst_length_1(bl[1]), .lock_1(lock[1]),
        .grant_1(grant_1), .done_1(done_1),
        .m_rd_req(m_rd_req), .m_wr_req(m_wr_req),
        .m_addr(m_addr), .m_burst_length(m_burst_length),
        .m_axi_done(m_axi_done), .curr_state(curr_state)
    );

    typedef struct {
        int          id;
        bit          dir;
        logic [31:0] addr;
        logic [11:0] bl;
    } op_t;

    op_t exp_q [$];
    int  tests = 0;
    int  fails = 0;
    int  viol  = 0;
    int  rr_m  = 0;
    bit  auto_resp = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic done_of(input int i);
        return (i == 0) ? done_0 : done_1;
    endfunction

    task automatic wait_done(input int i);
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (done_of(i)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL done_timeout req%0d: got no done expected done", i);
        end
    endtask

    task automatic issue(input int i, input bit d,
                         input logic [31:0] a, input logic [11:0] b);
        addr[i] = a;
        bl[i] = b;
        if (d) wr_req[i] = 1;
        else rd_req[i] = 1;
    endtask

    task automatic run_req(input int i, input int kind,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [11:0] b0, input logic [11:0] b1,
                           input bit d0, input bit d1);
        case (kind)
            1: begin
                issue(i, d0, a0, b0);
                wait_done(i);
                rd_req[i] = 0;
                wr_req[i] = 0;
            end
            2: begin
                addr[i] = a0;
                bl[i] = b0;
                rd_req[i] = 1;
                wr_req[i] = 1;
                wait_done(i);
                rd_req[i] = 0;
                addr[i] = a1;
                bl[i] = b1;
                wait_done(i);
                wr_req[i] = 0;
            end
            3: begin
                lock[i] = 1;
                issue(i, d0, a0, b0);
                wait_done(i);
                rd_req[i] = 0;
                wr_req[i] = 0;
                @(posedge clk);
                #1;
                issue(i, d1, a1, b1);
                wait_done(i);
                rd_req[i] = 0;
                wr_req[i] = 0;
                lock[i] = 0;
            end
            default: ;
        endcase
    endtask

    function automatic logic [11:0] rand_bl();
        if ($urandom_range(0, 3) == 0) return 12'd0;
        return 12'($urandom_range(1, 300));
    endfunction

    // kind: 0 idle, 1 single op, 2 rd+wr together, 3 locked pair
    task automatic scenario(input int k0, input int k1, input bit rnd_dir);
        int          kind [2];
        op_t         ops [2][2];
        int          n [2];
        bit          chain [2];
        int          idx [2];
        logic [31:0] ra [2][2];
        logic [11:0] rb [2][2];
        bit          rdir [2][2];
        int          w;
        kind[0] = k0;
        kind[1] = k1;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                ra[i][j] = $urandom;
                rb[i][j] = rand_bl();
                rdir[i][j] = rnd_dir ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            n[i] = (kind[i] == 0) ? 0 : (kind[i] == 1) ? 1 : 2;
            chain[i] = (kind[i] == 3);
            idx[i] = 0;
            if (kind[i] == 2) begin
                rdir[i][0] = 0;
                rdir[i][1] = 1;
            end
            for (int j = 0; j < 2; j++)
                ops[i][j] = '{i, rdir[i][j], ra[i][j], rb[i][j]};
        end
        // Grant order from the round-robin and lock rules
        while (idx[0] < n[0] || idx[1] < n[1]) begin
            if (idx[0] < n[0] && idx[1] < n[1]) w = rr_m;
            else w = (idx[0] < n[0]) ? 0 : 1;
            exp_q.push_back(ops[w][idx[w]]);
            idx[w]++;
            if (chain[w] && idx[w] < n[w]) begin
                exp_q.push_back(ops[w][idx[w]]);
                idx[w]++;
            end
            rr_m = 1 - w;
        end
        fork
            run_req(0, kind[0], ra[0][0], ra[0][1], rb[0][0], rb[0][1],
                    rdir[0][0], rdir[0][1]);
            run_req(1, kind[1], ra[1][0], ra[1][1], rb[1][0], rb[1][1],
                    rdir[1][0], rdir[1][1]);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("scb_drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Master model: random latency, occasional stray done while not busy
    initial begin
        int d;
        m_axi_done = 0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_resp) begin
                if (m_rd_req | m_wr_req) begin
                    d = $urandom_range(0, 4);
                    repeat (d) @(posedge clk);
                    #1;
                    m_axi_done = 1;
                    @(posedge clk);
                    #1;
                    m_axi_done = 0;
                end else if ($urandom_range(0, 7) == 0) begin
                    m_axi_done = 1;
                    @(posedge clk);
                    #1;
                    m_axi_done = 0;
                end
            end
        end
    end

    // Monitor: capture each master command, score it on the done pulse
    initial begin
        bit          prev_req = 0;
        bit          cmd_seen = 0;
        bit          c_dir = 0;
        int          c_id = 0;
        logic [31:0] c_addr = 0;
        logic [11:0] c_bl = 0;
        op_t         e;
        int          id;
        bit          bad;
        forever begin
            @(posedge clk);
            #1;
            if (grant_0 & grant_1) viol++;
            if (m_rd_req & m_wr_req) viol++;
            if (curr_state == 2'd0) cmd_seen = 0;
            if (m_rd_req | m_wr_req) begin
                if (!prev_req) begin
                    cmd_seen = 1;
                    c_dir = m_wr_req;
                    c_addr = m_addr;
                    c_bl = m_burst_length;
                    c_id = grant_1 ? 1 : 0;
                end else if (m_addr != c_addr || m_burst_length != c_bl
                             || m_wr_req != c_dir) begin
                    viol++;
                end
            end
            prev_req = m_rd_req | m_wr_req;
            if (done_0 | done_1) begin
                id = done_1 ? 1 : 0;
                if (done_0 & done_1) viol++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scb_unexpected: got done%0d expected none", id);
                end else begin
                    e = exp_q.pop_front();
                    if (e.bl == 0) bad = cmd_seen;
                    else bad = !cmd_seen || c_dir != e.dir || c_addr != e.addr
                               || c_bl != e.bl || c_id != e.id;
                    if (e.id != id) bad = 1;
                    if (bad) begin
                        fails++;
                        $display("FAIL scb_txn: got id%0d cmd%0d dir%0d a=%h bl=%0d expected id%0d dir%0d a=%h bl=%0d",
                                 id, cmd_seen, c_dir, c_addr, c_bl,
                                 e.id, e.dir, e.addr, e.bl);
                    end
                end
                cmd_seen = 0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            rd_req[i] = 0;
            wr_req[i] = 0;
            addr[i] = 0;
            bl[i] = 0;
            lock[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state",
            {grant_0, grant_1, done_0, done_1, m_rd_req, m_wr_req,
             curr_state, m_addr, m_burst_length}, 64'd0);
        reset = 0;
        @(posedge clk);
        #1;

        // Single read, master completes 4 cycles after the request
        issue(0, 0, 32'h1000_0000, 12'd200);
        exp_q.push_back('{0, 1'b0, 32'h1000_0000, 12'd200});
        @(posedge clk);
        #1;
        chk("single_cmd", {m_rd_req, m_wr_req, grant_0, grant_1, curr_state,
                           m_addr, m_burst_length},
            {4'b1010, 2'd1, 32'h1000_0000, 12'd200});
        repeat (3) @(posedge clk);
        #1;
        chk("busy_hold", {m_rd_req, m_addr}, {1'b1, 32'h1000_0000});
        m_axi_done = 1;
        @(posedge clk);
        #1;
        chk("single_done", {done_0, done_1, m_rd_req, curr_state},
            {3'b100, 2'd2});
        m_axi_done = 0;
        rd_req[0] = 0;
        @(posedge clk);
        #1;
        chk("single_idle", {done_0, grant_0, curr_state}, {2'b00, 2'd0});

        // Zero burst on requester 1
        issue(1, 0, 32'h0000_abcd, 12'd0);
        exp_q.push_back('{1, 1'b0, 32'h0000_abcd, 12'd0});
        @(posedge clk);
        #1;
        chk("zero_burst", {done_1, grant_1, m_rd_req, m_wr_req, curr_state},
            {4'b1100, 2'd2});
        rd_req[1] = 0;
        @(posedge clk);
        #1;
        chk("zero_idle", {done_1, grant_1, curr_state}, {2'b00, 2'd0});

        // Reset mid-BUSY, then a stray master done
        issue(0, 1, 32'h0000_5555, 12'd7);
        @(posedge clk);
        #1;
        chk("pre_reset_wr", {m_rd_req, m_wr_req}, 2'b01);
        reset = 1;
        wr_req[0] = 0;
        @(posedge clk);
        #1;
        reset = 0;
        chk("mid_reset",
            {grant_0, grant_1, done_0, done_1, m_rd_req, m_wr_req,
             curr_state, m_addr, m_burst_length}, 64'd0);
        m_axi_done = 1;
        @(posedge clk);
        #1;
        m_axi_done = 0;
        chk("stray_done", {done_0, done_1, curr_state}, 4'd0);
        rr_m = 0;

        auto_resp = 1;
        scenario(0, 1, 0);
        scenario(1, 1, 0);
        scenario(1, 1, 0);
        scenario(2, 0, 0);
        scenario(3, 1, 0);
        scenario(3, 3, 1);
        for (int s = 0; s < 40; s++) begin
            int k0 = $urandom_range(0, 3);
            int k1 = $urandom_range(0, 3);
            if (k0 == 0 && k1 == 0) k1 = 1;
            scenario(k0, k1, 1);
        end
        auto_resp = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("invariants", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
